// File: rtl/alu_defs.sv
// Shared funct codes and mul/div sequencer states for the execute-stage ALU.
package alu_defs;

  // Logic / arithmetic
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  // Compare
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  // Shifts (SRL/SRA are aliases of the variable forms)
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  // HI/LO moves
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  // Multi-cycle
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// Results are presented combinationally while in S_DONE (done_c high).
module alu_muldiv_iter import alu_defs::*; #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic         is_signed,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done_c,
  output logic [N-1:0] hi_c,
  output logic [N-1:0] lo_c,
  output logic         div_zero_c
);

  localparam int unsigned CW = $clog2(N);

  md_state_t     state;
  logic [N:0]    acc;        // partial product high half / partial remainder
  logic [N-1:0]  qr;         // multiplier bits / quotient bits
  logic [N-1:0]  m;          // multiplicand / divisor magnitude
  logic [CW-1:0] cnt;
  logic          div_q, neg_q, neg_r, dz;

  logic          a_neg, b_neg;
  logic [N-1:0]  a_mag, b_mag;
  logic [N:0]    madd, psum, shl;
  logic [N:0]    acc_nxt;
  logic [N-1:0]  qr_nxt;
  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0]  q_fix, r_fix;

  assign a_neg = is_signed & a[N-1];
  assign b_neg = is_signed & b[N-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  assign madd = acc + {1'b0, m};
  assign psum = qr[0] ? madd : acc;
  assign shl  = {acc[N-1:0], qr[N-1]};

  // One multiply or divide step
  always_comb begin
    acc_nxt = acc;
    qr_nxt  = qr;
    if (div_q) begin
      if (shl >= {1'b0, m}) begin
        acc_nxt = shl - {1'b0, m};
        qr_nxt  = {qr[N-2:0], 1'b1};
      end else begin
        acc_nxt = shl;
        qr_nxt  = {qr[N-2:0], 1'b0};
      end
    end else begin
      acc_nxt = {1'b0, psum[N:1]};
      qr_nxt  = {psum[0], qr[N-1:1]};
    end
  end

  assign prod     = {acc[N-1:0], qr};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  assign q_fix    = neg_q ? (~qr + 1'b1) : qr;
  assign r_fix    = neg_r ? (~acc[N-1:0] + 1'b1) : acc[N-1:0];

  // Sign fix-up and divide-by-zero result selection
  always_comb begin
    hi_c = r_fix;
    lo_c = q_fix;
    if (dz) begin
      hi_c = acc[N-1:0];
      lo_c = '1;
    end else if (!div_q) begin
      {hi_c, lo_c} = prod_fix;
    end
  end

  assign done_c     = (state == S_DONE);
  assign div_zero_c = dz;

  // Sequencer: latch magnitudes, iterate N steps, hold result for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      qr    <= '0;
      m     <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_BUSY;
            cnt   <= CW'(N - 1);
            div_q <= is_div;
            neg_q <= a_neg ^ b_neg;
            if (is_div) begin
              m     <= b_mag;
              qr    <= a_mag;
              neg_r <= a_neg;
              dz    <= (b == '0);
              acc   <= (b == '0) ? {1'b0, a} : '0;
            end else begin
              m     <= a_mag;
              qr    <= b_mag;
              neg_r <= 1'b0;
              dz    <= 1'b0;
              acc   <= '0;
            end
          end
        end
        S_BUSY: begin
          if (dz) begin
            state <= S_DONE;
          end else begin
            acc <= acc_nxt;
            qr  <= qr_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: registered single-cycle ops plus iterative mul/div into HI/LO.
module alu_muldiv import alu_defs::*; #(
  parameter int unsigned N      = 32,
  parameter bit          OVF_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  input  logic [5:0]   operation,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         overflow,
  output logic         div_zero,
  output logic         illegal
);

  localparam int unsigned SW = $clog2(N);

  logic [N-1:0]  hi_r, lo_r;
  logic          accept, is_md, md_start;
  logic          md_done_c, md_dz_c;
  logic [N-1:0]  md_hi_c, md_lo_c;
  logic [N-1:0]  sum, diff, alu_res;
  logic          alu_ovf, alu_ill;
  logic [SW-1:0] shamt;

  assign accept   = in_valid & in_ready;
  assign is_md    = (operation[5:2] == 4'b0110);
  assign md_start = accept & is_md;
  assign sum      = input1 + input2;
  assign diff     = input1 - input2;
  assign shamt    = input2[SW-1:0];

  alu_muldiv_iter #(.N(N)) u_iter (
    .clk        (clk),
    .rst        (rst),
    .start      (md_start),
    .is_div     (operation[1]),
    .is_signed  (~operation[0]),
    .a          (input1),
    .b          (input2),
    .done_c     (md_done_c),
    .hi_c       (md_hi_c),
    .lo_c       (md_lo_c),
    .div_zero_c (md_dz_c)
  );

  // Single-cycle result, overflow and illegal decode
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (operation)
      F_ADD: begin
        alu_res = sum;
        alu_ovf = OVF_EN & (input1[N-1] == input2[N-1]) & (sum[N-1] != input1[N-1]);
      end
      F_ADDU: alu_res = sum;
      F_SUB: begin
        alu_res = diff;
        alu_ovf = OVF_EN & (input1[N-1] != input2[N-1]) & (diff[N-1] != input1[N-1]);
      end
      F_SUBU:          alu_res = diff;
      F_AND:           alu_res = input1 & input2;
      F_OR:            alu_res = input1 | input2;
      F_XOR:           alu_res = input1 ^ input2;
      F_NOR:           alu_res = ~(input1 | input2);
      F_SLT:           alu_res = {{(N-1){1'b0}}, ($signed(input1) < $signed(input2))};
      F_SLTU:          alu_res = {{(N-1){1'b0}}, (input1 < input2)};
      F_SLLV:          alu_res = input1 << shamt;
      F_SRLV, F_SRL:   alu_res = input1 >> shamt;
      F_SRAV, F_SRA:   alu_res = $unsigned($signed(input1) >>> shamt);
      F_MFHI:          alu_res = hi_r;
      F_MFLO:          alu_res = lo_r;
      F_MULT, F_MULTU, F_DIV, F_DIVU: alu_res = '0;
      default:         alu_ill = 1'b1;
    endcase
  end

  // Output registers, HI/LO and the accept/stall handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      out_valid <= 1'b0;
      if (md_done_c) begin
        hi_r      <= md_hi_c;
        lo_r      <= md_lo_c;
        out_valid <= 1'b1;
        result    <= md_lo_c;
        zero      <= (md_lo_c == '0);
        overflow  <= 1'b0;
        div_zero  <= md_dz_c;
        illegal   <= 1'b0;
        in_ready  <= 1'b1;
      end else if (accept) begin
        if (is_md) begin
          in_ready <= 1'b0;
        end else begin
          out_valid <= 1'b1;
          result    <= alu_res;
          zero      <= (alu_res == '0);
          overflow  <= alu_ovf;
          div_zero  <= 1'b0;
          illegal   <= alu_ill;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: vector table, hand corner cases, random vs model.
module tb_alu_muldiv;

  localparam int unsigned N = 32;
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] input1 = '0;
  logic [N-1:0] input2 = '0;
  logic [5:0]   operation = '0;
  logic         out_valid;
  logic [N-1:0] result;
  logic         zero, overflow, div_zero, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;

  typedef struct {
    logic [5:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         z;
    logic         ov;
    logic         il;
  } vec_t;
  vec_t tbl[$];

  logic [5:0] ops [0:22] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h02, 6'h03, 6'h10,
                             6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};

  alu_muldiv #(.N(N), .OVF_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input1    (input1),
    .input2    (input2),
    .operation (operation),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .div_zero  (div_zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] res, input logic ov, input logic il);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.z = (res == '0); v.ov = ov; v.il = il;
    tbl.push_back(v);
  endtask

  // Reference: architectural result from plain integer arithmetic; updates model HI/LO.
  task automatic model(input logic [5:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] r, output logic ov, output logic dz,
                       output logic il, output int lat);
    longint sa, sb, p, q, rm;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    r = '0; ov = 1'b0; dz = 1'b0; il = 1'b0; lat = 1;
    case (op)
      6'h20: begin r = a + b; ov = (sa + sb > S_MAX) || (sa + sb < S_MIN); end
      6'h21: r = a + b;
      6'h22: begin r = a - b; ov = (sa - sb > S_MAX) || (sa - sb < S_MIN); end
      6'h23: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = (sa < sb) ? N'(1) : N'(0);
      6'h2B: r = (ua < ub) ? N'(1) : N'(0);
      6'h04: r = a << b[4:0];
      6'h06, 6'h02: r = a >> b[4:0];
      6'h07, 6'h03: r = N'(sa >>> b[4:0]);
      6'h10: r = m_hi;
      6'h12: r = m_lo;
      6'h18: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = int'(N) + 2; end
      6'h19: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; r = m_lo; lat = int'(N) + 2; end
      6'h1A, 6'h1B: begin
        if (b == '0) begin
          m_hi = a; m_lo = '1; dz = 1'b1; lat = 3;
        end else if (op == 6'h1A) begin
          q = sa / sb; rm = sa % sb;
          m_lo = q[31:0]; m_hi = rm[31:0]; lat = int'(N) + 2;
        end else begin
          up = ua / ub; m_lo = up[31:0];
          up = ua % ub; m_hi = up[31:0]; lat = int'(N) + 2;
        end
        r = m_lo;
      end
      default: il = 1'b1;
    endcase
  endtask

  // Present one op at a negedge, wait for out_valid, return the observed outputs.
  task automatic exec(input logic [5:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                      output logic [N-1:0] r, output logic z, output logic ov,
                      output logic dz, output logic il, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; operation = op; input1 = a; input2 = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      check("in_ready_busy", 64'(in_ready), 64'(0));
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: op %h never produced out_valid", op);
    end
    r = result; z = zero; ov = overflow; dz = div_zero; il = illegal;
  endtask

  task automatic run_model(input string tag, input logic [5:0] op,
                           input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] er, ar;
    logic eo, ed, ei, az, ao, ad, ai;
    int el, al;
    model(op, a, b, er, eo, ed, ei, el);
    exec(op, a, b, ar, az, ao, ad, ai, al);
    check({tag, "_result"},   64'(ar), 64'(er));
    check({tag, "_zero"},     64'(az), 64'(er == '0));
    check({tag, "_overflow"}, 64'(ao), 64'(eo));
    check({tag, "_div_zero"}, 64'(ad), 64'(ed));
    check({tag, "_illegal"},  64'(ai), 64'(ei));
    check({tag, "_latency"},  64'(al), 64'(el));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [N-1:0] r;
    logic z, ov, dz, il;
    int lat;
    logic saw;
    logic [5:0] op;
    logic [N-1:0] a, b;

    add_vec(6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0);
    add_vec(6'h21, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
    add_vec(6'h22, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0);
    add_vec(6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    add_vec(6'h2B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
    add_vec(6'h07, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0);
    add_vec(6'h06, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0);
    add_vec(6'h04, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0);
    add_vec(6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
    add_vec(6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0);
    add_vec(6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
    add_vec(6'h27, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    add_vec(6'h22, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0);
    add_vec(6'h23, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0);
    add_vec(6'h03, 32'h80000000, 32'h00000001, 32'hC0000000, 1'b0, 1'b0);
    add_vec(6'h02, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0);
    add_vec(6'h2A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
    add_vec(6'h2B, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    add_vec(6'h3F, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1);

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_result",    64'(result),    64'(0));
    check("rst_zero",      64'(zero),      64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_overflow",  64'(overflow),  64'(0));
    check("rst_div_zero",  64'(div_zero),  64'(0));
    check("rst_illegal",   64'(illegal),   64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back
    foreach (tbl[i]) begin
      exec(tbl[i].op, tbl[i].a, tbl[i].b, r, z, ov, dz, il, lat);
      check($sformatf("vec%0d_result", i),   64'(r),   64'(tbl[i].res));
      check($sformatf("vec%0d_zero", i),     64'(z),   64'(tbl[i].z));
      check($sformatf("vec%0d_overflow", i), 64'(ov),  64'(tbl[i].ov));
      check($sformatf("vec%0d_illegal", i),  64'(il),  64'(tbl[i].il));
      check($sformatf("vec%0d_div_zero", i), 64'(dz),  64'(0));
      check($sformatf("vec%0d_latency", i),  64'(lat), 64'(1));
    end

    // Multi-cycle corner cases
    exec(6'h18, 32'hFFFFFFFD, 32'h00000007, r, z, ov, dz, il, lat);
    check("mult_lo",      64'(r),        64'(32'hFFFFFFEB));
    check("mult_latency", 64'(lat),      64'(N + 2));
    check("mult_ready",   64'(in_ready), 64'(1));
    exec(6'h10, '0, '0, r, z, ov, dz, il, lat);
    check("mult_mfhi", 64'(r), 64'(32'hFFFFFFFF));
    exec(6'h12, '0, '0, r, z, ov, dz, il, lat);
    check("mult_mflo", 64'(r), 64'(32'hFFFFFFEB));

    exec(6'h1A, 32'hFFFFFFF9, 32'h00000002, r, z, ov, dz, il, lat);
    check("div_lo",    64'(r),  64'(32'hFFFFFFFD));
    check("div_dzflag", 64'(dz), 64'(0));
    exec(6'h10, '0, '0, r, z, ov, dz, il, lat);
    check("div_mfhi", 64'(r), 64'(32'hFFFFFFFF));

    exec(6'h1B, 32'h00000007, 32'h00000000, r, z, ov, dz, il, lat);
    check("divz_flag",    64'(dz),  64'(1));
    check("divz_lo",      64'(r),   64'(32'hFFFFFFFF));
    check("divz_latency", 64'(lat), 64'(3));
    exec(6'h10, '0, '0, r, z, ov, dz, il, lat);
    check("divz_mfhi", 64'(r), 64'(7));

    exec(6'h1A, 32'h80000000, 32'hFFFFFFFF, r, z, ov, dz, il, lat);
    check("divneg_lo",   64'(r),  64'(32'h80000000));
    check("divneg_flag", 64'(dz), 64'(0));
    check("divneg_ovf",  64'(ov), 64'(0));
    exec(6'h10, '0, '0, r, z, ov, dz, il, lat);
    check("divneg_mfhi", 64'(r), 64'(0));
    check("divneg_zero", 64'(z), 64'(1));

    exec(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, r, z, ov, dz, il, lat);
    check("multu_lo", 64'(r), 64'(1));
    exec(6'h10, '0, '0, r, z, ov, dz, il, lat);
    check("multu_mfhi", 64'(r), 64'(32'hFFFFFFFE));

    // Reset in the middle of a MULT
    in_valid = 1'b1; operation = 6'h18; input1 = 32'hFFFFFFFD; input2 = 32'h00000007;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
    saw = 1'b0;
    repeat (N + 6) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("midrst_no_valid", 64'(saw),      64'(0));
    check("midrst_ready",    64'(in_ready), 64'(1));
    check("midrst_result",   64'(result),   64'(0));
    check("midrst_zero",     64'(zero),     64'(1));
    m_hi = '0;
    m_lo = '0;
    run_model("midrst_mfhi", 6'h10, '0, '0);
    run_model("midrst_mflo", 6'h12, '0, '0);
    run_model("illegal_3f", 6'h3F, 32'h1, 32'h2);

    // Random ops against the reference model
    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 22)];
      for (int s = 0; s < 2; s++) begin
        case ($urandom_range(0, 7))
          0: b = '0;
          1: b = 32'h1;
          2: b = 32'hFFFFFFFF;
          3: b = 32'h80000000;
          4: b = 32'h7FFFFFFF;
          5: b = 32'($urandom_range(0, 40));
          default: b = $urandom();
        endcase
        if (s == 0) a = b;
      end
      run_model($sformatf("rnd%0d_op%02h", k, op), op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
